dmem_arbiter: RTL and testbench

//  Two-requester arbiter sharing the single-port data memory (data_mem) between the core load/store path
//  (port 0) and a DMA/debug master (port 1). Per-port valid/ready request channel, one-cycle response pulse.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_rr_arb2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: requester count, port
// indices, FSM state encoding and a small index-to-one-hot helper.
// Configuration macro consumed by users of this package: DMEM_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int   NUM_REQ   = 2;
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Expand a port index into its one-hot request/response bit.
    function automatic logic [1:0] port_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
// Ports:
//   valid_i        [1:0]  raw request valids
//   last_grant_i          index of the most recently granted port
//   mask_i         [1:0]  eligibility mask (all ones when no lock is held)
//   grant_onehot_o [1:0]  one-hot grant, zero when nothing is eligible
//   grant_idx_o           index of the granted port (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_grant_i,
    input  logic [1:0] mask_i,
    output logic [1:0] grant_onehot_o,
    output logic       grant_idx_o
);

    logic [1:0] eligible_s;

    // Pick the winner: on contention the port that did not win last time.
    always_comb begin
        eligible_s     = valid_i & mask_i;
        grant_idx_o    = 1'b0;
        grant_onehot_o = 2'b00;
        case (eligible_s)
            2'b11: begin
                grant_idx_o    = ~last_grant_i;
                grant_onehot_o = port_onehot(~last_grant_i);
            end
            2'b01: begin
                grant_idx_o    = 1'b0;
                grant_onehot_o = 2'b01;
            end
            2'b10: begin
                grant_idx_o    = 1'b1;
                grant_onehot_o = 2'b10;
            end
            default: begin
                grant_idx_o    = 1'b0;
                grant_onehot_o = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data memory between the core load/store path (port 0)
// and a DMA/debug master (port 1). One access in flight: handshake in IDLE,
// memory cycle in ACCESS, one-cycle response pulse in RESP.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req_valid/req_ready [1:0] per-port request handshake
//   req_write [1:0]           1 = store, 0 = load
//   req_addr  [2*AW-1:0]      port i at [i*AW +: AW]
//   req_wdata [2*N-1:0]       port i at [i*N +: N]
//   resp_valid [1:0]          one-cycle completion pulse per port
//   resp_rdata [N-1:0]        load data (zero for stores)
//   mem_write/mem_addr/mem_wdata/mem_rdata  data memory interface
//   req_lock [1:0]            only with DMEM_ARB_LOCK_EN: hold grant for owner
// Configuration: `define DMEM_ARB_LOCK_EN to enable the lock feature.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N  = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*N-1:0]  req_wdata,
    output logic [1:0]    resp_valid,
    output logic [N-1:0]  resp_rdata,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata
`ifdef DMEM_ARB_LOCK_EN
    ,
    input  logic [1:0]    req_lock
`endif
);

    arb_state_e    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          winner_q, winner_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0]  mem_wdata_q, mem_wdata_d;
    logic [1:0]    resp_valid_q, resp_valid_d;
    logic [N-1:0]  resp_rdata_q, resp_rdata_d;

    logic [1:0]    mask_s;
    logic [1:0]    grant_onehot_s;
    logic          grant_idx_s;
    logic          handshake_s;

`ifdef DMEM_ARB_LOCK_EN
    logic          lock_hold_q, lock_hold_d;
    logic          lock_owner_q, lock_owner_d;

    // While a lock is held only the owner is eligible.
    always_comb begin
        if (lock_hold_q) begin
            mask_s = port_onehot(lock_owner_q);
        end else begin
            mask_s = 2'b11;
        end
    end

    // Lock set/clear: taken from the req_lock bit at handshake, or dropped
    // when the owner goes quiet (no valid, no lock) while the FSM is idle.
    always_comb begin
        lock_hold_d  = lock_hold_q;
        lock_owner_d = lock_owner_q;
        if (handshake_s) begin
            lock_hold_d  = req_lock[grant_idx_s];
            lock_owner_d = grant_idx_s;
        end else if ((state_q == IDLE) && lock_hold_q &&
                     !req_valid[lock_owner_q] && !req_lock[lock_owner_q]) begin
            lock_hold_d  = 1'b0;
        end else begin
            lock_hold_d  = lock_hold_q;
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_hold_q  <= 1'b0;
            lock_owner_q <= 1'b0;
        end else begin
            lock_hold_q  <= lock_hold_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    // Pure round-robin: both ports always eligible.
    always_comb begin
        mask_s = 2'b11;
    end
`endif

    rr_arb2 u_rr_arb2 (
        .valid_i        (req_valid),
        .last_grant_i   (last_grant_q),
        .mask_i         (mask_s),
        .grant_onehot_o (grant_onehot_s),
        .grant_idx_o    (grant_idx_s)
    );

    assign handshake_s = (state_q == IDLE) && (grant_onehot_s != 2'b00);

    // FSM next state, request latching and response generation.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 2'b00;
        resp_rdata_d = resp_rdata_q;
        req_ready    = 2'b00;
        case (state_q)
            IDLE: begin
                req_ready = grant_onehot_s;
                if (handshake_s) begin
                    state_d      = ACCESS;
                    winner_d     = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    // mem_write is registered, so it is high for exactly the
                    // ACCESS cycle and also marks the access as a store there.
                    mem_write_d  = req_write[grant_idx_s];
                    mem_addr_d   = grant_idx_s ? req_addr[AW +: AW] : req_addr[0 +: AW];
                    mem_wdata_d  = grant_idx_s ? req_wdata[N +: N] : req_wdata[0 +: N];
                end else begin
                    state_d      = IDLE;
                end
            end
            ACCESS: begin
                if (mem_write_q) begin
                    resp_rdata_d = {N{1'b0}};
                end else begin
                    resp_rdata_d = mem_rdata;
                end
                resp_valid_d = port_onehot(winner_q);
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state and registered memory/response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            mem_wdata_q  <= {N{1'b0}};
            resp_valid_q <= 2'b00;
            resp_rdata_q <= {N{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a transaction-level model: each grant
// schedules its memory write and response pulse by cycle number, and a compare
// process checks every DUT output on every falling edge. A few literal checks
// pin the model to hand-computed values. Optional lock scenario under
// DMEM_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]  req_lock;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    dmem_arbiter #(.N(32), .AW(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_LOCK_EN
        ,
        .req_lock   (req_lock)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment: the data memory itself (combinational read, clocked write).
    bit [31:0] dmem [0:255];
    assign mem_rdata = dmem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int        m_last;
    int        next_free;
    bit [31:0] m_addr_hold, m_wdata_hold;
    bit [31:0] mmem [bit [31:0]];
    bit        exp_mw   [int];
    bit [31:0] mw_addr  [int];
    bit [31:0] mw_data  [int];
    int        exp_rport[int];
    bit [31:0] exp_rdata[int];
    bit        m_lock;
    int        m_owner;

    initial begin
        m_last = 1; next_free = 0; m_addr_hold = 0; m_wdata_hold = 0;
        m_lock = 0; m_owner = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                chk("rst_req_ready",  req_ready, 2'b00);
                chk("rst_resp_valid", resp_valid, 2'b00);
                chk("rst_resp_rdata", resp_rdata, 32'h0);
                chk("rst_mem_write",  mem_write, 1'b0);
                chk("rst_mem_addr",   mem_addr, 32'h0);
                chk("rst_mem_wdata",  mem_wdata, 32'h0);
                exp_mw.delete(); mw_addr.delete(); mw_data.delete();
                exp_rport.delete(); exp_rdata.delete();
                m_last = 1; next_free = 0; m_addr_hold = 0; m_wdata_hold = 0;
                m_lock = 0; m_owner = 0;
            end else begin
                bit [1:0]  elig;
                bit [1:0]  e_ready;
                bit [1:0]  e_resp;
                bit        free;
                int        w;
                bit [31:0] a, d;
                bit        wr;
                free = (cyc >= next_free);
                elig = req_valid;
                if (m_lock) elig = elig & (m_owner == 1 ? 2'b10 : 2'b01);
                w = -1;
                if (free) begin
                    if (elig == 2'b11) w = (m_last == 1) ? 0 : 1;
                    else if (elig[0]) w = 0;
                    else if (elig[1]) w = 1;
                end
                e_ready = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
                e_resp  = !exp_rport.exists(cyc) ? 2'b00 : (exp_rport[cyc] == 1 ? 2'b10 : 2'b01);
                chk("req_ready",  req_ready, e_ready);
                chk("mem_write",  mem_write, exp_mw.exists(cyc));
                chk("mem_addr",   mem_addr, m_addr_hold);
                chk("mem_wdata",  mem_wdata, m_wdata_hold);
                chk("resp_valid", resp_valid, e_resp);
                if (exp_rport.exists(cyc)) chk("resp_rdata", resp_rdata, exp_rdata[cyc]);
                if (exp_mw.exists(cyc)) mmem[mw_addr[cyc]] = mw_data[cyc];
`ifdef DMEM_ARB_LOCK_EN
                if (free && w < 0 && m_lock && !req_valid[m_owner] && !req_lock[m_owner]) m_lock = 0;
`endif
                if (w >= 0) begin
                    a  = req_addr[w*32 +: 32];
                    d  = req_wdata[w*32 +: 32];
                    wr = req_write[w];
                    m_last = w;
                    next_free = cyc + 3;
                    m_addr_hold = a;
                    m_wdata_hold = d;
                    if (wr) begin
                        exp_mw[cyc+1]  = 1'b1;
                        mw_addr[cyc+1] = a;
                        mw_data[cyc+1] = d;
                    end
                    exp_rport[cyc+2] = w;
                    exp_rdata[cyc+2] = wr ? 32'h0 : (mmem.exists(a) ? mmem[a] : 32'h0);
`ifdef DMEM_ARB_LOCK_EN
                    m_lock  = req_lock[w];
                    m_owner = w;
`endif
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int gport[$];
    int gcyc[$];

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request on one port; returns at posedge+1 after the handshake.
    task automatic xact(input int port, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, output int hs);
        bit found = 0;
        hs = -1;
        req_write[port] = wr;
        req_addr[port*32 +: 32]  = addr;
        req_wdata[port*32 +: 32] = wd;
        req_valid[port] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (!found) begin
                @(negedge clk);
                if (req_ready[port]) begin found = 1; hs = cyc; end
                @(posedge clk); #1;
            end
        end
        req_valid[port] = 1'b0;
        if (!found) chk("xact_timeout", 1'b0, 1'b1);
    endtask

    // Both ports request loads continuously until n grants are seen.
    task automatic run_both(input int n, input logic [31:0] a0, input logic [31:0] a1);
        gport.delete(); gcyc.delete();
        req_write = 2'b00;
        req_addr  = {a1, a0};
        req_valid = 2'b11;
        for (int k = 0; k < 60; k++) begin
            if (gport.size() < n) begin
                @(negedge clk);
                if (req_ready != 2'b00) begin
                    gport.push_back(req_ready[1] ? 1 : 0);
                    gcyc.push_back(cyc);
                end
                @(posedge clk); #1;
            end
        end
        req_valid = 2'b00;
        if (gport.size() < n) chk("run_both_timeout", gport.size(), n);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hs, hs2, c0;
        int exp_alt[4];
        exp_alt = '{0, 1, 0, 1};
        reset_n = 1'b0; req_valid = 2'b00; req_write = 2'b00;
        req_addr = 64'h0; req_wdata = 64'h0;
`ifdef DMEM_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Port 0 store 0x10 <= DEADBEEF.
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, hs);
        @(negedge clk);
        chk("st_mem_write", mem_write, 1'b1);
        chk("st_mem_addr",  mem_addr, 32'h10);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("st_resp_valid", resp_valid, 2'b01);
        chk("st_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;

        // Port 1 load 0x10 sees the stored value.
        xact(1, 1'b0, 32'h10, 32'h0, hs);
        @(negedge clk);
        chk("ld_mem_write", mem_write, 1'b0);
        @(negedge clk);
        chk("ld_resp_valid", resp_valid, 2'b10);
        chk("ld_resp_rdata", resp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Continuous contention: alternate 0,1,0,1, one grant per 3 cycles.
        run_both(4, 32'h10, 32'h40);
        for (int i = 0; i < 4; i++) begin
            if (i < gport.size()) chk("alt_port", gport[i], exp_alt[i]);
            if (i > 0 && i < gcyc.size()) chk("alt_spacing", gcyc[i] - gcyc[i-1], 3);
        end
        idle(3);

        // Port 1 alone right after port 1 was served.
        c0 = cyc;
        xact(1, 1'b0, 32'h40, 32'h0, hs);
        chk("p1_first_wait", hs - c0, 0);
        xact(1, 1'b1, 32'h44, 32'hCAFE0001, hs2);
        chk("p1_again_spacing", hs2 - hs, 3);
        idle(3);

        // Reset during the ACCESS cycle of a store.
        xact(0, 1'b1, 32'h20, 32'h12345678, hs);
        chk("pre_rst_mem_write", mem_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("async_mem_write_drop", mem_write, 1'b0);
        chk("async_resp_valid", resp_valid, 2'b00);
        idle(2);
        reset_n = 1'b1;
        chk("dropped_store", dmem[8], 32'h0);
        run_both(2, 32'h20, 32'h44);
        if (gport.size() > 0) chk("post_rst_first_port", gport[0], 0);
        if (gport.size() > 1) chk("post_rst_second_port", gport[1], 1);
        idle(4);

`ifdef DMEM_ARB_LOCK_EN
        begin
            int exp_lk[3];
            exp_lk = '{1, 1, 0};
            xact(0, 1'b0, 32'h10, 32'h0, hs);
            idle(3);
            gport.delete();
            req_write = 2'b00;
            req_addr  = {32'h44, 32'h10};
            req_lock  = 2'b10;
            req_valid = 2'b11;
            for (int k = 0; k < 40; k++) begin
                if (gport.size() < 3) begin
                    @(negedge clk);
                    if (req_ready != 2'b00) gport.push_back(req_ready[1] ? 1 : 0);
                    @(posedge clk); #1;
                    if (gport.size() == 1) req_lock = 2'b00;
                    if (gport.size() == 2) req_valid[1] = 1'b0;
                end
            end
            req_valid = 2'b00;
            if (gport.size() < 3) chk("lock_timeout", gport.size(), 3);
            for (int i = 0; i < 3; i++)
                if (i < gport.size()) chk("lock_port", gport[i], exp_lk[i]);
            idle(4);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
